// File: rtl/i2s_capture_sdram.sv
// i2s_capture_sdram: line-in I2S receiver that packs 16-bit samples into
// 128-bit words and writes them into a circular SDRAM region through an
// arbiter client port (wr/ac handshake, 22-bit word address).
// Optional build macro I2S_CAPTURE_MONO_EN: keep left samples only, 8 per word.
module i2s_capture_sdram #(
    parameter logic [21:0] BASE_ADDR   = 22'h200000,
    parameter logic [21:0] RING_WORDS  = 22'd65536,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         SClk,
    input  logic         LRClk,
    input  logic         Din,
    output logic         sdram_wr,
    output logic [21:0]  sdram_addr,
    output logic [127:0] sdram_data,
    output logic [15:0]  sdram_be,
    input  logic         sdram_ac,
    input  logic         sdram_wait,
    output logic         busy,
    output logic         overrun,
    output logic [21:0]  words_written
);
    typedef enum logic {IDLE, REQ} wr_state_t;

    localparam logic [21:0] LAST_ADDR = BASE_ADDR + RING_WORDS - 22'd1;

    logic [SYNC_STAGES-1:0] sclk_sync, lr_sync, din_sync;
    logic         sclk_s, lr_s, din_s, sclk_d, strobe;
    logic         en_d, en_rise, en_active, armed, arm_now;
    logic         lr_prev, chan;
    logic [4:0]   bit_cnt;
    logic [14:0]  sreg;
    logic [15:0]  sample_val;
    logic         sample_done, word_done;
    logic [127:0] word_data;
    logic [127:0] fifo_mem [2];
    logic         wr_idx, rd_idx;
    logic [1:0]   fifo_cnt;
    logic         push, pop;
    logic [21:0]  wr_ptr, ww_cnt;
    logic         overrun_q;
    wr_state_t    state_q, state_d;
    logic         unused_wait;

    // The arbiter's wait line does not influence the request handshake.
    assign unused_wait = sdram_wait;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign lr_s        = lr_sync[SYNC_STAGES-1];
    assign din_s       = din_sync[SYNC_STAGES-1];
    assign strobe      = sclk_s & ~sclk_d;
    assign en_rise     = enable & ~en_d;
    assign arm_now     = strobe & lr_prev & ~lr_s & en_active & ~armed;
    assign sample_done = strobe & (lr_s == lr_prev) & (bit_cnt == 5'd15);
    assign sample_val  = {sreg, din_s};
    assign busy        = armed | (fifo_cnt != 2'd0) | sdram_wr;
    assign overrun     = overrun_q;
    assign words_written = ww_cnt;

    // Codec pin synchronisers and SClk edge history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            din_sync  <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SClk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], LRClk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], Din};
            sclk_d    <= sclk_s;
        end
    end

    // Enable edge tracking; a rise only counts when the block is idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_d      <= 1'b0;
            en_active <= 1'b0;
            armed     <= 1'b0;
        end else begin
            en_d <= enable;
            if (!enable) begin
                en_active <= 1'b0;
                armed     <= 1'b0;
            end else begin
                if (en_rise && !busy) en_active <= 1'b1;
                if (arm_now)          armed     <= 1'b1;
            end
        end
    end

    // Slot deserialiser: LR change marks the delay bit, then 16 bits MSB-first
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lr_prev <= 1'b0;
            chan    <= 1'b0;
            bit_cnt <= '0;
            sreg    <= '0;
        end else if (strobe) begin
            lr_prev <= lr_s;
            if (lr_s != lr_prev) begin
                bit_cnt <= '0;
                chan    <= lr_s;
            end else if (bit_cnt < 5'd16) begin
                sreg    <= {sreg[13:0], din_s};
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

`ifdef I2S_CAPTURE_MONO_EN
    logic [111:0] pack_buf;
    logic [2:0]   smp_cnt;

    assign word_done = armed & sample_done & ~chan & (smp_cnt == 3'd7);
    assign word_data = {sample_val, pack_buf};

    // Left-only packing: sample k lands in bits [16k+15:16k]
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pack_buf <= '0;
            smp_cnt  <= '0;
        end else if (!armed) begin
            smp_cnt <= '0;
        end else if (sample_done && !chan) begin
            for (int unsigned i = 0; i < 7; i++)
                if (smp_cnt == 3'(i)) pack_buf[16*i +: 16] <= sample_val;
            smp_cnt <= smp_cnt + 3'd1;
        end
    end
`else
    logic [95:0] pack_buf;
    logic [15:0] left_smp;
    logic        have_left;
    logic [1:0]  frame_cnt;

    assign word_done = armed & sample_done & chan & have_left & (frame_cnt == 2'd3);
    // Frame 3 goes straight into the outgoing word, so only frames 0..2 are buffered
    assign word_data = {left_smp, sample_val, pack_buf};

    // Stereo packing: frame k is {L,R} in bits [32k+31:32k]
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pack_buf  <= '0;
            left_smp  <= '0;
            have_left <= 1'b0;
            frame_cnt <= '0;
        end else if (!armed) begin
            have_left <= 1'b0;
            frame_cnt <= '0;
        end else if (sample_done) begin
            if (!chan) begin
                left_smp  <= sample_val;
                have_left <= 1'b1;
            end else if (have_left) begin
                for (int unsigned i = 0; i < 3; i++)
                    if (frame_cnt == 2'(i)) pack_buf[32*i +: 32] <= {left_smp, sample_val};
                have_left <= 1'b0;
                frame_cnt <= frame_cnt + 2'd1;
            end
        end
    end
`endif

    assign pop  = (state_q == REQ) & sdram_ac;
    assign push = word_done & ((fifo_cnt != 2'd2) | pop);

    // Two-entry write FIFO; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= word_data;
                wr_idx           <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Ring pointer, acknowledged-word count and sticky overrun flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= BASE_ADDR;
            ww_cnt    <= '0;
            overrun_q <= 1'b0;
        end else if (en_rise && !busy) begin
            wr_ptr    <= BASE_ADDR;
            ww_cnt    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (pop) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? BASE_ADDR : wr_ptr + 22'd1;
                ww_cnt <= ww_cnt + 22'd1;
            end
            if (word_done && !push) overrun_q <= 1'b1;
        end
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Write FSM next state: request while the FIFO holds data, release on ac
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_cnt != 2'd0) state_d = REQ;
            REQ:     if (sdram_ac)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write FSM outputs: address and data are zero outside a request
    always_comb begin
        sdram_wr   = 1'b0;
        sdram_addr = '0;
        sdram_data = '0;
        sdram_be   = '1;
        if (state_q == REQ) begin
            sdram_wr   = 1'b1;
            sdram_addr = wr_ptr;
            sdram_data = fifo_mem[rd_idx];
        end
    end

endmodule
